// File: rtl/pacc_row_sched.sv
// Row scheduler for the PolyVec_PAcc unit: walks all matrix rows (mode 0)
// or a single selected row (mode 1), launching the accumulator, storing each
// result and guarding every row with a watchdog.
module pacc_row_sched #(
    parameter int KYBER_K     = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] row_sel,
    input  logic             abort,
    input  logic             pacc_done,
    output logic             pacc_enable,
    output logic [IDX_W-1:0] row_idx,
    output logic             res_we,
    output logic [IDX_W-1:0] res_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W:0]   ROW_LIM  = (IDX_W+1)'(KYBER_K);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(KYBER_K - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_STORE,
        ST_FINISH
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] row_q, row_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             err_q, err_nx;
    logic             mode_q, mode_nx;
    logic             row_illegal;

    assign row_illegal = ({1'b0, row_sel} >= ROW_LIM);

    // State, row pointer, watchdog counter and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            row_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nx;
            row_q  <= row_nx;
            cnt_q  <= cnt_nx;
            err_q  <= err_nx;
            mode_q <= mode_nx;
        end
    end

    // Next-state and datapath update; abort overrides every busy-state decision.
    always_comb begin
        state_nx = state;
        row_nx   = row_q;
        cnt_nx   = cnt_q;
        err_nx   = err_q;
        mode_nx  = mode_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_nx  = 1'b0;
                    mode_nx = mode;
                    if (mode) begin
                        row_nx = row_sel;
                        if (row_illegal) begin
                            err_nx   = 1'b1;
                            state_nx = ST_FINISH;
                        end else begin
                            state_nx = ST_LAUNCH;
                        end
                    end else begin
                        row_nx   = '0;
                        state_nx = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_nx   = '0;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (pacc_done) begin
                    state_nx = ST_STORE;
                end else if (cnt_q == CNT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = ST_FINISH;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            ST_STORE: begin
                if (!mode_q && (row_q != LAST_ROW)) begin
                    row_nx   = row_q + IDX_W'(1);
                    state_nx = ST_LAUNCH;
                end else begin
                    state_nx = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Abort discards whatever the busy state decided, including a
        // coincident pacc_done, but leaves the error flag as it was.
        if (abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
            row_nx   = '0;
            cnt_nx   = cnt_q;
            err_nx   = err_q;
        end
    end

    assign pacc_enable = (state == ST_LAUNCH);
    assign res_we      = (state == ST_STORE);
    assign done        = (state == ST_FINISH);
    assign busy        = (state != ST_IDLE);
    assign row_idx     = row_q;
    assign res_idx     = row_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pacc_row_sched.sv
// Scoreboard bench for pacc_row_sched: expected launches, stores and job
// completions are queued when a job is started and retired by a monitor.
module tb_pacc_row_sched;

    localparam int K  = 2;
    localparam int TO = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [IW-1:0] row_sel = '0;
    logic          abort = 1'b0;
    logic          stub_done = 1'b0;
    logic          man_done = 1'b0;
    logic          pacc_done;
    logic          pacc_enable;
    logic [IW-1:0] row_idx;
    logic          res_we;
    logic [IW-1:0] res_idx;
    logic          busy;
    logic          done;
    logic          err;

    assign pacc_done = stub_done | man_done;

    pacc_row_sched #(
        .KYBER_K    (K),
        .TIMEOUT_CYC(TO),
        .IDX_W      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .row_sel    (row_sel),
        .abort      (abort),
        .pacc_done  (pacc_done),
        .pacc_enable(pacc_enable),
        .row_idx    (row_idx),
        .res_we     (res_we),
        .res_idx    (res_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected job completion: err value and optional latency references
    // (negedges after the last pacc_done / after the last launch, -1 = skip).
    typedef struct {
        logic err;
        int   lat_pd;
        int   lat_en;
    } done_t;

    int    exp_en_q[$];
    int    exp_we_q[$];
    done_t exp_done_q[$];

    int    n_neg = 0;
    int    pd_n = -100;
    int    en_n = -100;
    int    done_seen = 0;
    int    e_row;
    done_t e_done;

    // Monitor: retire expectations as the DUT produces strobes.
    always @(negedge clk) begin
        n_neg++;
        if (!rst) begin
            if (pacc_done) pd_n = n_neg;
            if (pacc_enable) begin
                if (exp_en_q.size() == 0) begin
                    check_val("en_unexpected", 1, 0);
                end else begin
                    e_row = exp_en_q.pop_front();
                    check_val("en_row", row_idx, e_row);
                end
                en_n = n_neg;
            end
            if (res_we) begin
                if (exp_we_q.size() == 0) begin
                    check_val("we_unexpected", 1, 0);
                end else begin
                    e_row = exp_we_q.pop_front();
                    check_val("we_idx", res_idx, e_row);
                    check_val("we_lat", n_neg - pd_n, 1);
                end
            end
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    check_val("done_unexpected", 1, 0);
                end else begin
                    e_done = exp_done_q.pop_front();
                    check_val("done_err", err, e_done.err);
                    if (e_done.lat_pd >= 0) check_val("done_lat_pd", n_neg - pd_n, e_done.lat_pd);
                    if (e_done.lat_en >= 0) check_val("done_lat_en", n_neg - en_n, e_done.lat_en);
                end
            end
        end
    end

    // PAcc stub: answers each launch with a pacc_done pulse after stub_dly cycles.
    int stub_dly = 10;
    bit stub_on  = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (pacc_enable && stub_on && !rst) begin
                repeat (stub_dly) @(posedge clk);
                #1 stub_done = 1'b1;
                @(posedge clk);
                #1 stub_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m, input logic [IW-1:0] sel, input logic ab);
        start   = 1'b1;
        mode    = m;
        row_sel = sel;
        abort   = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_seen < target; i++) begin
            @(negedge clk);
            #1;
        end
        check_val(tag, done_seen, target);
    endtask

    task automatic drain_check(input string tag);
        check_val({tag, "_en_left"}, exp_en_q.size(), 0);
        check_val({tag, "_we_left"}, exp_we_q.size(), 0);
        check_val({tag, "_done_left"}, exp_done_q.size(), 0);
    endtask

    task automatic push_full_job();
        for (int r = 0; r < K; r++) begin
            exp_en_q.push_back(r);
            exp_we_q.push_back(r);
        end
        exp_done_q.push_back('{1'b0, 2, -1});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_enable", pacc_enable, 0);
        check_val("rst_we", res_we, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_row", row_idx, 0);
        check_val("rst_res_idx", res_idx, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Full A.s job; a start pulsed mid-job must be dropped.
        push_full_job();
        pulse_start(1'b0, '0, 1'b0);
        repeat (3) tick();
        pulse_start(1'b1, 2'd1, 1'b0);
        wait_done(1, 200, "m0_done_count");
        repeat (30) tick();
        check_val("m0_single_done", done_seen, 1);
        check_val("m0_err", err, 0);
        drain_check("m0");

        // Single row 1.
        exp_en_q.push_back(1);
        exp_we_q.push_back(1);
        exp_done_q.push_back('{1'b0, 2, -1});
        pulse_start(1'b1, 2'd1, 1'b0);
        wait_done(2, 100, "m1_done_count");
        repeat (5) tick();
        drain_check("m1");

        // Illegal row 3: error, no launch, busy drops right after done.
        exp_done_q.push_back('{1'b1, -1, -1});
        pulse_start(1'b1, 2'd3, 1'b0);
        wait_done(3, 20, "ill_done_count");
        check_val("ill_busy_fin", busy, 1);
        @(negedge clk);
        check_val("ill_busy_after", busy, 0);
        check_val("ill_err_sticky", err, 1);
        tick();
        drain_check("ill");

        // Watchdog expiry: done 16 cycles after entering WAIT.
        stub_on = 1'b0;
        exp_en_q.push_back(0);
        exp_done_q.push_back('{1'b1, -1, TO + 1});
        pulse_start(1'b1, 2'd0, 1'b0);
        wait_done(4, 60, "to_done_count");
        tick();
        check_val("to_err", err, 1);
        drain_check("to");
        stub_on = 1'b1;

        // Next accepted start clears the error and runs normally.
        push_full_job();
        pulse_start(1'b0, '0, 1'b0);
        check_val("clr_err", err, 0);
        wait_done(5, 200, "clr_done_count");
        repeat (5) tick();
        drain_check("clr");

        // Abort coincident with pacc_done on row 0.
        stub_on = 1'b0;
        exp_en_q.push_back(0);
        pulse_start(1'b0, '0, 1'b0);
        repeat (4) tick();
        man_done = 1'b1;
        abort    = 1'b1;
        tick();
        man_done = 1'b0;
        abort    = 1'b0;
        check_val("ab_busy", busy, 0);
        check_val("ab_row", row_idx, 0);
        repeat (20) tick();
        check_val("ab_no_done", done_seen, 5);
        drain_check("ab");
        stub_on = 1'b1;

        // Start together with abort in IDLE is accepted.
        exp_en_q.push_back(0);
        exp_we_q.push_back(0);
        exp_done_q.push_back('{1'b0, 2, -1});
        pulse_start(1'b1, 2'd0, 1'b1);
        wait_done(6, 100, "sa_done_count");
        repeat (5) tick();
        drain_check("sa");

        // Reset during WAIT after an ignored start: everything discarded.
        stub_on = 1'b0;
        exp_en_q.push_back(0);
        pulse_start(1'b0, '0, 1'b0);
        repeat (4) tick();
        pulse_start(1'b1, 2'd1, 1'b0);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check_val("mr_busy", busy, 0);
        check_val("mr_enable", pacc_enable, 0);
        check_val("mr_we", res_we, 0);
        check_val("mr_done", done, 0);
        check_val("mr_err", err, 0);
        check_val("mr_row", row_idx, 0);
        check_val("mr_res_idx", res_idx, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) tick();
        check_val("mr_no_done", done_seen, 6);
        check_val("mr_idle", busy, 0);
        drain_check("mr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pacc_row_sched.md
PACC_ROW_SCHED -- requirements
Module: pacc_row_sched

Interface
REQ-001 SHALL have parameter KYBER_K, default 2, number of matrix rows (polyvec_pacc runs per full job).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, maximum cycles to wait for pacc_done per row.
REQ-003 SHALL have parameter IDX_W, default 2, width of row indices; 2^IDX_W > KYBER_K.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  job request, sampled only in IDLE.
REQ-007 mode  input  1  0 = all KYBER_K rows (A·s), 1 = single row (inner product); sampled with start.
REQ-008 row_sel  input  IDX_W  row for mode 1; sampled with start.
REQ-009 abort  input  1  cancel the current job.
REQ-010 pacc_done  input  1  completion pulse from the PolyVec_PAcc unit.
REQ-011 pacc_enable  output  1  one-cycle launch pulse to the PolyVec_PAcc unit.
REQ-012 row_idx  output  IDX_W  row currently routed to the PAcc operand muxes.
REQ-013 res_we  output  1  one-cycle write strobe for the result buffer.
REQ-014 res_idx  output  IDX_W  result buffer slot; equals row_idx whenever res_we=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle job-complete pulse.
REQ-017 err  output  1  sticky error flag (timeout or illegal row_sel); cleared by the next accepted start.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, STORE, FINISH; all outputs registered or decoded from the state register only.
REQ-019 IDLE + start=1: mode 0 -> row_idx=0, mode 1 -> row_idx=row_sel, err cleared; go to LAUNCH.
REQ-020 IDLE + start=1 + mode=1 + row_sel>=KYBER_K: err=1, go to FINISH; no pacc_enable issued.
REQ-021 LAUNCH: pacc_enable=1 for exactly this cycle; watchdog counter cleared; go to WAIT.
REQ-022 WAIT: counter increments every cycle; pacc_done=1 -> STORE; counter reaching TIMEOUT_CYC-1 without pacc_done -> err=1, go to FINISH.
REQ-023 pacc_done SHALL be ignored in IDLE, LAUNCH, STORE and FINISH.
REQ-024 STORE: res_we=1, res_idx=row_idx for this cycle only; mode 0 and row_idx<KYBER_K-1 -> row_idx+1, go to LAUNCH; otherwise go to FINISH.
REQ-025 FINISH: done=1 for this cycle only; go to IDLE; row_idx holds its last value.
REQ-026 start while busy=1 SHALL be ignored and not queued.
REQ-027 abort=1 in any non-IDLE state: go to IDLE next cycle; no done, res_we or pacc_enable in that cycle or after; err unchanged; row_idx reset to 0.
REQ-028 abort and pacc_done in the same WAIT cycle: abort wins; no res_we.
REQ-029 abort and start in the same IDLE cycle: start is accepted (abort has no effect in IDLE).
REQ-030 Latency, mode 1: start at edge 0 -> pacc_enable in cycle 1; pacc_done seen at edge N -> res_we in cycle N+1, done in cycle N+2.
REQ-031 Mode 0 SHALL issue exactly KYBER_K launches and KYBER_K res_we strobes, with row indices 0..KYBER_K-1 in order.

Reset
REQ-032 rst=1 SHALL force IDLE immediately; pacc_enable, res_we, done, busy, err = 0; row_idx, res_idx, counter = 0.
REQ-033 rst asserted mid-job SHALL discard the job; no done after rst deasserts.

Verification
REQ-034 mode 0, K=2, stub pacc_done 10 cycles after each enable -> enables at row 0 then row 1, res_we with res_idx 0 then 1, single done, err=0.
REQ-035 mode 1, row_sel=1 -> exactly one pacc_enable with row_idx=1, one res_we with res_idx=1, done 2 cycles after pacc_done.
REQ-036 mode 1, row_sel=3 (K=2) -> no pacc_enable, err=1, done pulse, busy falls the next cycle.
REQ-037 pacc_done never asserted, TIMEOUT_CYC=16 -> err=1 and done 16 cycles after entering WAIT; next start clears err.
REQ-038 abort coincident with pacc_done during row 0 -> no res_we, no done, IDLE next cycle; a new start then runs normally.
REQ-039 rst asserted during WAIT and start pulsed while busy -> outputs reset immediately; the ignored start produces no second job.
